fp_mult_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined `fp_mult` instance between NREQ requesters. Each requester presents operands a, b and a rounding mode with a valid/ready handshake. Results return in issue order on a single tagged response channel through an output FIFO. A credit counter stops the non-stallable multiplier pipeline from overrunning that FIFO.

---
 rtl/fp_mult_arbiter_if.sv | 30 +++
 rtl/fp_mult_arbiter.sv | 92 +++++++++
 tb/tb_fp_mult_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_arbiter_if.sv
// fp_mult_arbiter_if: requester, multiplier and response signals of the shared fp_mult arbiter
interface fp_mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [3*NREQ-1:0] req_rnd;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [2:0] mul_rnd;
  logic [31:0] mul_z;
  logic [7:0] mul_status;
  logic resp_valid;
  logic resp_ready;
  logic [IDW-1:0] resp_id;
  logic [31:0] resp_z;
  logic [7:0] resp_status;
  logic idle;
  modport master (
    output req_valid, req_a, req_b, req_rnd, mul_z, mul_status, resp_ready,
    input req_ready, mul_a, mul_b, mul_rnd, resp_valid, resp_id, resp_z, resp_status, idle
  );
  modport slave (
    input req_valid, req_a, req_b, req_rnd, mul_z, mul_status, resp_ready,
    output req_ready, mul_a, mul_b, mul_rnd, resp_valid, resp_id, resp_z, resp_status, idle
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one pipelined fp_mult with tagged in-order responses
module fp_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT = 1,
  parameter int DEPTH = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  fp_mult_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0] z;
    logic [7:0] st;
  } ent_t;
  logic [IDW-1:0] last_grant, g, idx;
  logic found, issue_ok, issue, wr, pop;
  logic [LAT-1:0] tv;
  logic [IDW-1:0] tid [LAT];
  logic [CW-1:0] inflight, fifo_count;
  logic [PW-1:0] wp, rp;
  ent_t mem [DEPTH];
  ent_t head;
  // rotating priority search starting just after the last granted requester
  always_comb begin
    g = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  assign issue_ok = !rst && (inflight + fifo_count < CW'(DEPTH));
  assign issue = issue_ok && found;
  assign bus.req_ready = issue ? NREQ'(1) << g : '0;
  assign bus.mul_a = issue ? bus.req_a[32*g +: 32] : '0;
  assign bus.mul_b = issue ? bus.req_b[32*g +: 32] : '0;
  assign bus.mul_rnd = issue ? bus.req_rnd[3*g +: 3] : '0;
  assign wr = tv[LAT-1];
  assign head = mem[rp];
  assign bus.resp_valid = fifo_count != '0;
  assign bus.resp_id = bus.resp_valid ? head.id : '0;
  assign bus.resp_z = bus.resp_valid ? head.z : '0;
  assign bus.resp_status = bus.resp_valid ? head.st : '0;
  assign pop = bus.resp_valid && bus.resp_ready;
  assign bus.idle = inflight == '0 && fifo_count == '0;
  // tag pipeline tracks which requester owns each multiplier stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv <= '0;
      for (int i = 0; i < LAT; i++) tid[i] <= '0;
      inflight <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      tv[0] <= issue;
      tid[0] <= g;
      for (int i = 1; i < LAT; i++) begin
        tv[i] <= tv[i-1];
        tid[i] <= tid[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(wr);
      if (issue) last_grant <= g;
    end
  end
  // result FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
    end else begin
      if (wr) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      fifo_count <= fifo_count + CW'(wr) - CW'(pop);
    end
  end
  // result storage; contents are only meaningful below fifo_count
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= '{id: tid[LAT-1], z: bus.mul_z, st: bus.mul_status};
  end
  // credits must keep the non-stallable pipe from writing into a full FIFO
  always_ff @(posedge clk) begin
    if (!rst && wr) assert (fifo_count != CW'(DEPTH));
  end
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: directed and random checks of fp_mult_arbiter against a queue-based model
module tb_fp_mult_arbiter;
  localparam int NREQ = 4;
  localparam int LAT = 1;
  localparam int DEPTH = 4;
  localparam int IDW = 2;
  typedef struct {
    int id;
    logic [31:0] z;
    logic [7:0] st;
    int t;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lg = NREQ - 1;
  int iss_cnt;
  ent_t q[$];
  logic [31:0] a_op [NREQ];
  logic [31:0] b_op [NREQ];
  logic [2:0] r_op [NREQ];
  logic [31:0] zp [LAT];
  logic [7:0] sp [LAT];
  logic [NREQ-1:0] obs_ready;
  logic obs_rv, obs_idle;
  logic [IDW-1:0] obs_id;
  logic [31:0] obs_z;
  logic [7:0] obs_st;
  int grants [8];

  fp_mult_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  fp_mult_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0] e;
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'b0, p[47]};
    return {a[31] ^ b[31], e[7:0], p[47] ? p[46:24] : p[45:23]};
  endfunction

  function automatic logic [7:0] sfn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    return a[7:0] ^ b[7:0] ^ {5'b0, r};
  endfunction

  // behavioural multiplier with fixed latency LAT
  always @(posedge clk) begin
    zp[0] <= fmul(bus.mul_a, bus.mul_b);
    sp[0] <= sfn(bus.mul_a, bus.mul_b, bus.mul_rnd);
    for (int i = 1; i < LAT; i++) begin
      zp[i] <= zp[i-1];
      sp[i] <= sp[i-1];
    end
  end
  assign bus.mul_z = zp[LAT-1];
  assign bus.mul_status = sp[LAT-1];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic rr, input logic r, input bit rnd_ops);
    bit found, iss, hv;
    int g;
    logic [NREQ-1:0] er;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (rnd_ops) begin
        a_op[i] = $urandom;
        b_op[i] = $urandom;
        r_op[i] = 3'($urandom_range(0, 4));
      end
      bus.req_a[32*i +: 32] = a_op[i];
      bus.req_b[32*i +: 32] = b_op[i];
      bus.req_rnd[3*i +: 3] = r_op[i];
    end
    bus.req_valid = v;
    bus.resp_ready = rr;
    rst = r;
    #1;
    found = 0;
    g = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && v[(lg + k) % NREQ]) begin
        found = 1;
        g = (lg + k) % NREQ;
      end
    end
    iss = !r && q.size() < DEPTH && found;
    er = iss ? NREQ'(1) << g : '0;
    hv = !r && q.size() > 0 && cyc >= q[0].t + LAT + 1;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("mul_a", 64'(bus.mul_a), iss ? 64'(a_op[g]) : 64'(0));
    chk("mul_b", 64'(bus.mul_b), iss ? 64'(b_op[g]) : 64'(0));
    chk("mul_rnd", 64'(bus.mul_rnd), iss ? 64'(r_op[g]) : 64'(0));
    chk("resp_valid", 64'(bus.resp_valid), 64'(hv));
    if (hv) begin
      chk("resp_id", 64'(bus.resp_id), 64'(q[0].id));
      chk("resp_z", 64'(bus.resp_z), 64'(q[0].z));
      chk("resp_status", 64'(bus.resp_status), 64'(q[0].st));
    end else if (r) begin
      chk("rst_resp_id", 64'(bus.resp_id), 64'(0));
      chk("rst_resp_z", 64'(bus.resp_z), 64'(0));
      chk("rst_resp_status", 64'(bus.resp_status), 64'(0));
    end
    chk("idle", 64'(bus.idle), 64'(r || q.size() == 0));
    obs_ready = bus.req_ready;
    obs_rv = bus.resp_valid;
    obs_idle = bus.idle;
    obs_id = bus.resp_id;
    obs_z = bus.resp_z;
    obs_st = bus.resp_status;
    @(posedge clk);
    if (r) begin
      q.delete();
      lg = NREQ - 1;
    end else begin
      if (hv && rr) void'(q.pop_front());
      if (iss) begin
        q.push_back('{id: g, z: fmul(a_op[g], b_op[g]), st: sfn(a_op[g], b_op[g], r_op[g]), t: cyc});
        lg = g;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + DEPTH + 2; i++) step('0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_rnd = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
      r_op[i] = '0;
    end
    step('1, 1'b0, 1'b1, 1'b1);
    chk("reset_idle", 64'(obs_idle), 64'(1));
    step('0, 1'b1, 1'b0, 1'b1);

    a_op[2] = 32'h3FC00000;
    b_op[2] = 32'h40000000;
    r_op[2] = 3'b000;
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    chk("single_ready", 64'(obs_ready), 64'(4'b0100));
    for (int i = 0; i < LAT; i++) begin
      step('0, 1'b1, 1'b0, 1'b0);
      chk("single_early", 64'(obs_rv), 64'(0));
    end
    step('0, 1'b1, 1'b0, 1'b0);
    chk("single_valid", 64'(obs_rv), 64'(1));
    chk("single_id", 64'(obs_id), 64'(2));
    chk("single_z", 64'(obs_z), 64'(32'h40400000));
    drain();

    step('0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step('1, 1'b1, 1'b0, 1'b1);
      grants[i] = $clog2(int'(obs_ready));
      chk("rr_grant", 64'(grants[i]), 64'(i % 4));
    end
    drain();

    iss_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b0011, 1'b0, 1'b0, 1'b1);
      if (obs_ready != '0) iss_cnt++;
    end
    chk("bp_issues", 64'(iss_cnt), 64'(DEPTH));
    chk("bp_stalled", 64'(obs_ready), 64'(0));
    step(4'b0011, 1'b1, 1'b0, 1'b1);
    chk("bp_pop_cycle_ready", 64'(obs_ready), 64'(0));
    step(4'b0011, 1'b1, 1'b0, 1'b1);
    chk("bp_resume", 64'(obs_ready != '0), 64'(1));
    for (int i = 0; i < 10; i++) step(4'b0011, 1'b1, 1'b0, 1'b1);
    drain();

    step('0, 1'b1, 1'b1, 1'b1);
    step(4'b1000, 1'b1, 1'b0, 1'b1);
    chk("fair_r3", 64'(obs_ready), 64'(4'b1000));
    step('0, 1'b1, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    step(4'b1010, 1'b1, 1'b0, 1'b1);
    chk("fair_r1", 64'(obs_ready), 64'(4'b0010));
    drain();

    for (int i = 0; i < 3; i++) step('1, 1'b0, 1'b0, 1'b1);
    step('1, 1'b0, 1'b1, 1'b1);
    chk("midrst_idle", 64'(obs_idle), 64'(1));
    chk("midrst_ready", 64'(obs_ready), 64'(0));
    step('0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step('0, 1'b1, 1'b0, 1'b1);
      chk("no_stale", 64'(obs_rv), 64'(0));
    end

    a_op[1] = 32'h3F8000A5;
    b_op[1] = 32'h3F800000;
    r_op[1] = 3'b000;
    step(4'b0010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    chk("status_st", 64'(obs_st), 64'(8'hA5));
    chk("status_id", 64'(obs_id), 64'(1));
    chk("status_z", 64'(obs_z), 64'(32'h3F8000A5));
    drain();

    for (int i = 0; i < 300; i++)
      step(NREQ'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
